// File: rtl/decode_stage_gen.sv
// Decode stage: register file, sign-extended immediate, branch/jump redirect and a 2-entry output FIFO.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle write-back to the register read ports.
module decode_stage_gen #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     inst_i,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [5:0]      out_op_o,
   output logic [5:0]      out_funct_o,
   output logic [4:0]      out_rs_o,
   output logic [4:0]      out_rt_o,
   output logic [4:0]      out_rd_o,
   output logic [XLEN-1:0] out_rs_data_o,
   output logic [XLEN-1:0] out_rt_data_o,
   output logic [XLEN-1:0] out_imm_o,
   output logic            br_taken_o,
   output logic            jmp_o,
   output logic [XLEN-1:0] target_o
);

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   typedef struct packed {
      logic [5:0]      op;
      logic [5:0]      funct;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
      logic [XLEN-1:0] imm;
   } entry_t;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   entry_t          fifo_q [2];
   entry_t          fifo_d [2];
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      count_q, count_d;
   logic            load_pend_q, load_pend_d;
   logic [4:0]      load_rt_q, load_rt_d;

   logic [5:0]      op;
   logic [4:0]      rd_addr [2];
   logic [XLEN-1:0] rd_data [2];
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] jmp_tgt;
   logic [27:0]     jmp_field;
   logic            hazard;
   logic            push;
   logic            pop;
   entry_t          new_entry;

   assign op         = inst_i[31:26];
   assign rd_addr[0] = inst_i[25:21];
   assign rd_addr[1] = inst_i[20:16];
   assign imm        = {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};
   assign br_tgt     = pc_i + (imm << 2);
   assign jmp_field  = {inst_i[25:0], 2'b00};

   // Jump target keeps the PC bits above the 28-bit region when the datapath is wide enough.
   generate
      if (XLEN > 28) begin : g_jmp_wide
         assign jmp_tgt = {pc_i[XLEN-1:28], jmp_field};
      end else begin : g_jmp_narrow
         assign jmp_tgt = jmp_field[XLEN-1:0];
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd_port
         logic in_range;
         assign in_range = (32'(rd_addr[gi]) < NREG);
         always_comb begin
            rd_data[gi] = '0;
            if (in_range) begin
               rd_data[gi] = regs_q[rd_addr[gi][AW-1:0]];
`ifdef DECODE_BYPASS_EN
               if (wb_we_i && (wb_addr_i != '0) && (rd_addr[gi][AW-1:0] == wb_addr_i)) begin
                  rd_data[gi] = wb_data_i;
               end
`endif
            end
         end
      end
   endgenerate

   assign hazard      = load_pend_q && (load_rt_q != 5'd0) &&
                        ((load_rt_q == rd_addr[0]) || (load_rt_q == rd_addr[1]));
   assign in_ready_o  = (count_q < 2'd2) && !hazard && !flush_i && !rst_i;
   assign out_valid_o = (count_q != 2'd0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   assign new_entry = '{op: op, funct: inst_i[5:0], rs: rd_addr[0], rt: rd_addr[1],
                        rd: inst_i[15:11], rs_data: rd_data[0], rt_data: rd_data[1], imm: imm};

   assign br_taken_o = push && (op == OP_BEQ) && (rd_data[0] == rd_data[1]);
   assign jmp_o      = push && (op == OP_J);
   assign target_o   = br_taken_o ? br_tgt : (jmp_o ? jmp_tgt : '0);

   assign out_op_o      = fifo_q[rd_ptr_q].op;
   assign out_funct_o   = fifo_q[rd_ptr_q].funct;
   assign out_rs_o      = fifo_q[rd_ptr_q].rs;
   assign out_rt_o      = fifo_q[rd_ptr_q].rt;
   assign out_rd_o      = fifo_q[rd_ptr_q].rd;
   assign out_rs_data_o = fifo_q[rd_ptr_q].rs_data;
   assign out_rt_data_o = fifo_q[rd_ptr_q].rt_data;
   assign out_imm_o     = fifo_q[rd_ptr_q].imm;

   always_comb begin
      regs_d = regs_q;
      if (wb_we_i && (wb_addr_i != '0)) begin
         regs_d[wb_addr_i] = wb_data_i;
      end
   end

   // Flush wins over a simultaneous pop; push cannot coincide with flush since in_ready_o is low.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = new_entry;
      end
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      load_pend_d = !flush_i && push && (op == OP_LW);
      load_rt_d   = load_pend_d ? rd_addr[1] : 5'd0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         load_pend_q <= 1'b0;
         load_rt_q   <= 5'd0;
      end else begin
         regs_q      <= regs_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         load_pend_q <= load_pend_d;
         load_rt_q   <= load_rt_d;
      end
   end

endmodule

// File: tb/tb_decode_stage_gen.sv
// Bench for decode_stage_gen: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue/array reference model.
module tb_decode_stage_gen;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] pc_i;
   logic [31:0] inst_i;
   logic        wb_we_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [5:0]  out_op_o, out_funct_o;
   logic [4:0]  out_rs_o, out_rt_o, out_rd_o;
   logic [31:0] out_rs_data_o, out_rt_data_o, out_imm_o;
   logic        br_taken_o, jmp_o;
   logic [31:0] target_o;

   decode_stage_gen #(.XLEN(32), .NREG(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .pc_i(pc_i), .inst_i(inst_i),
      .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_op_o(out_op_o), .out_funct_o(out_funct_o),
      .out_rs_o(out_rs_o), .out_rt_o(out_rt_o), .out_rd_o(out_rd_o),
      .out_rs_data_o(out_rs_data_o), .out_rt_data_o(out_rt_data_o), .out_imm_o(out_imm_o),
      .br_taken_o(br_taken_o), .jmp_o(jmp_o), .target_o(target_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd, imm;
   } ent_t;

   logic [31:0] mregs [32];
   ent_t        mq [$];
   bit          m_lp;
   logic [4:0]  m_lrt;

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      m_lp  = 0;
      m_lrt = '0;
   end

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef DECODE_BYPASS_EN
      if (wb_we_i && wb_addr_i == a) return wb_data_i;
`endif
      return mregs[a];
   endfunction

   // Model: evaluate expectations from the current inputs and model state, then advance the model
   // to the state the DUT will hold after the coming rising edge.
   always @(negedge clk_i) begin
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic [31:0] rsd, rtd, sext, exp_tgt;
      bit          hz, exp_ready, acc, exp_br, exp_jmp, do_pop;
      ent_t        e;
      op   = inst_i[31:26];
      rs   = inst_i[25:21];
      rt   = inst_i[20:16];
      rsd  = mread(rs);
      rtd  = mread(rt);
      sext = inst_i[15] ? (32'hFFFF_0000 | 32'(inst_i[15:0])) : 32'(inst_i[15:0]);
      hz   = m_lp && m_lrt != 0 && (m_lrt == rs || m_lrt == rt);
      exp_ready = !rst_i && mq.size() < 2 && !hz && !flush_i;
      acc     = in_valid_i && exp_ready;
      exp_br  = acc && op == 6'h04 && rsd == rtd;
      exp_jmp = acc && op == 6'h02;
      exp_tgt = 32'd0;
      if (exp_br) exp_tgt = pc_i + sext * 4;
      else if (exp_jmp) exp_tgt = (pc_i & 32'hF000_0000) | (32'(inst_i[25:0]) * 4);
      check("in_ready", in_ready_o, exp_ready);
      check("out_valid", out_valid_o, mq.size() != 0);
      check("br_taken", br_taken_o, exp_br);
      check("jmp", jmp_o, exp_jmp);
      check("target", target_o, exp_tgt);
      if (mq.size() != 0) begin
         check("out_op", out_op_o, mq[0].op);
         check("out_funct", out_funct_o, mq[0].funct);
         check("out_rs", out_rs_o, mq[0].rs);
         check("out_rt", out_rt_o, mq[0].rt);
         check("out_rd", out_rd_o, mq[0].rd);
         check("out_rs_data", out_rs_data_o, mq[0].rsd);
         check("out_rt_data", out_rt_data_o, mq[0].rtd);
         check("out_imm", out_imm_o, mq[0].imm);
      end
      if (rst_i) begin
         for (int i = 0; i < 32; i++) mregs[i] = '0;
         mq.delete();
         m_lp  = 0;
         m_lrt = '0;
      end else begin
         do_pop = mq.size() != 0 && out_ready_i;
         if (flush_i) begin
            mq.delete();
         end else begin
            if (do_pop) begin
               $display("pop  op=%0h rd=%0d rs_data=%0h rt_data=%0h", mq[0].op, mq[0].rd, mq[0].rsd, mq[0].rtd);
               void'(mq.pop_front());
            end
            if (acc) begin
               e.op = op; e.funct = inst_i[5:0]; e.rs = rs; e.rt = rt; e.rd = inst_i[15:11];
               e.rsd = rsd; e.rtd = rtd; e.imm = sext;
               mq.push_back(e);
            end
         end
         m_lp  = !flush_i && acc && op == 6'h23;
         m_lrt = rt;
         if (wb_we_i && wb_addr_i != 0) mregs[wb_addr_i] = wb_data_i;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [5:0] op;
      case ($urandom_range(0, 4))
         0: op = 6'h00;
         1: op = 6'h23;
         2: op = 6'h04;
         3: op = 6'h02;
         default: op = 6'($urandom);
      endcase
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
   endfunction

   initial begin
      logic [31:0] exp_byp;
      rst_i = 1; in_valid_i = 0; pc_i = 0; inst_i = 0; wb_we_i = 0; wb_addr_i = 0;
      wb_data_i = 0; flush_i = 0; out_ready_i = 0;
      tick(); tick();
      rst_i = 0;
      @(negedge clk_i);
      check("lit_rst_valid", out_valid_o, 0);
      check("lit_rst_br", br_taken_o, 0);
      check("lit_rst_jmp", jmp_o, 0);

      // Write-back then read of r5
      wb_we_i = 1; wb_addr_i = 5; wb_data_i = 32'h1234; tick();
      wb_we_i = 0; in_valid_i = 1; inst_i = mk_r(5, 0, 9);
      @(negedge clk_i); check("lit_r5_ready", in_ready_o, 1);
      tick();
      in_valid_i = 0;
      @(negedge clk_i);
      check("lit_r5_valid", out_valid_o, 1);
      check("lit_r5_data", out_rs_data_o, 32'h0000_1234);
      out_ready_i = 1; tick();

      // Back-pressure: third push stalls, then in-order drain
      out_ready_i = 0; in_valid_i = 1; inst_i = mk_r(0, 0, 1); tick();
      inst_i = mk_r(0, 0, 2); tick();
      inst_i = mk_r(0, 0, 3);
      @(negedge clk_i); check("lit_full_stall", in_ready_o, 0);
      tick();
      out_ready_i = 1;
      @(negedge clk_i); check("lit_order0", out_rd_o, 1);
      tick();
      @(negedge clk_i); check("lit_order1", out_rd_o, 2); check("lit_order1_ready", in_ready_o, 1);
      tick();
      in_valid_i = 0;
      @(negedge clk_i); check("lit_order2", out_rd_o, 3);
      tick();

      // Load-use stall and the rt = 0 exemption
      in_valid_i = 1; inst_i = mk_i(6'h23, 0, 7, 0); tick();
      inst_i = mk_r(7, 0, 4);
      @(negedge clk_i); check("lit_lw_stall", in_ready_o, 0);
      tick();
      @(negedge clk_i); check("lit_lw_release", in_ready_o, 1);
      tick();
      inst_i = mk_i(6'h23, 0, 0, 0); tick();
      inst_i = mk_r(0, 0, 4);
      @(negedge clk_i); check("lit_lw_r0", in_ready_o, 1);
      tick();
      in_valid_i = 0;

      // beq taken with negative offset, then j
      wb_we_i = 1; wb_addr_i = 1; wb_data_i = 32'h55; tick();
      wb_addr_i = 2; tick();
      wb_we_i = 0; in_valid_i = 1; pc_i = 32'h100; inst_i = mk_i(6'h04, 1, 2, 16'hFFFF);
      @(negedge clk_i); check("lit_beq_taken", br_taken_o, 1); check("lit_beq_tgt", target_o, 32'hFC);
      tick();
      pc_i = 32'h4000_0000; inst_i = {6'h02, 26'h10};
      @(negedge clk_i);
      check("lit_j", jmp_o, 1); check("lit_j_br", br_taken_o, 0); check("lit_j_tgt", target_o, 32'h4000_0040);
      tick();
      in_valid_i = 0; pc_i = 0; tick();

      // Same-cycle write-back and read of r3
      wb_we_i = 1; wb_addr_i = 3; wb_data_i = 32'h11; tick();
      wb_data_i = 32'hAA; in_valid_i = 1; inst_i = mk_r(3, 0, 0); out_ready_i = 0; tick();
      wb_we_i = 0; in_valid_i = 0;
`ifdef DECODE_BYPASS_EN
      exp_byp = 32'hAA;
`else
      exp_byp = 32'h11;
`endif
      @(negedge clk_i); check("lit_bypass", out_rs_data_o, exp_byp);
      out_ready_i = 1; tick();

      // Flush with two buffered entries, then reset mid-stream
      out_ready_i = 0; in_valid_i = 1; inst_i = mk_r(1, 2, 1); tick();
      inst_i = mk_r(1, 2, 2); tick();
      in_valid_i = 0; flush_i = 1; out_ready_i = 1;
      @(negedge clk_i); check("lit_flush_pre", out_valid_o, 1);
      tick();
      flush_i = 0;
      @(negedge clk_i); check("lit_flush_empty", out_valid_o, 0);
      out_ready_i = 0; in_valid_i = 1; inst_i = mk_r(5, 0, 6); tick(); tick();
      rst_i = 1; in_valid_i = 0; wb_we_i = 1; wb_addr_i = 5; wb_data_i = 32'h77;
      @(negedge clk_i); check("lit_rst_ready", in_ready_o, 0);
      tick();
      rst_i = 0; wb_we_i = 0;
      @(negedge clk_i);
      check("lit_rst2_valid", out_valid_o, 0);
      check("lit_rst2_br", br_taken_o, 0);
      check("lit_rst2_jmp", jmp_o, 0);
      in_valid_i = 1; inst_i = mk_r(5, 0, 0); tick();
      in_valid_i = 0;
      @(negedge clk_i); check("lit_r5_after_rst", out_rs_data_o, 32'h0);
      out_ready_i = 1; tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_i       = ($urandom_range(0, 149) == 0);
         flush_i     = ($urandom_range(0, 29) == 0);
         in_valid_i  = ($urandom_range(0, 9) < 7);
         out_ready_i = ($urandom_range(0, 9) < 6);
         wb_we_i     = ($urandom_range(0, 9) < 4);
         wb_addr_i   = 5'($urandom_range(0, 7));
         wb_data_i   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
         pc_i        = $urandom & 32'hFFFF_FFFC;
         inst_i      = rand_inst();
         tick();
      end
      rst_i = 0; flush_i = 0; in_valid_i = 0; wb_we_i = 0;
      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage_gen.md
DECODE_STAGE_GEN -- requirements
Module: decode_stage_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width (range 16..64).
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of 2, range 2..32); AW = clog2(NREG).
REQ-003 SHALL have port clk_i  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have ports in_valid_i in 1, in_ready_o out 1, pc_i in XLEN, inst_i in 32, meaning the upstream valid/ready instruction handshake.
REQ-006 SHALL have ports wb_we_i in 1, wb_addr_i in AW, wb_data_i in XLEN, meaning the write-back register write.
REQ-007 SHALL have port flush_i  in  1  meaning discard all buffered instructions.
REQ-008 SHALL have ports out_valid_o out 1, out_ready_i in 1, meaning the downstream handshake.
REQ-009 SHALL have ports out_op_o out 6, out_funct_o out 6, out_rs_o/out_rt_o/out_rd_o out 5 each, out_rs_data_o/out_rt_data_o/out_imm_o out XLEN each, meaning the decoded payload.
REQ-010 SHALL have ports br_taken_o out 1, jmp_o out 1, target_o out XLEN, meaning control-transfer redirect.

Function
REQ-011 SHALL hold NREG x XLEN registers; register 0 SHALL read 0, and writes to it SHALL be ignored.
REQ-012 SHALL read rs = inst_i[25:21] and rt = inst_i[20:16] combinationally; a field >= NREG SHALL read 0, and a write with wb_addr_i = 0 SHALL be ignored.
REQ-013 SHALL sign-extend inst_i[15:0] to XLEN for out_imm_o.
REQ-014 SHALL buffer decoded entries in a 2-entry FIFO; out_valid_o = (count != 0); out payload = head entry.
REQ-015 SHALL accept (push) when in_valid_i && in_ready_o; SHALL pop when out_valid_o && out_ready_i.
REQ-016 in_ready_o SHALL equal (count < 2) && !hazard && !flush_i.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged; data order SHALL be preserved.
REQ-018 load_pend SHALL be set for exactly the cycle after accepting opcode 6'h23 (lw), and SHALL store that instruction's rt.
REQ-019 hazard SHALL be asserted when load_pend && stored rt != 0 && stored rt equals the incoming rs or rt (one-bubble load-use stall).
REQ-020 load_pend SHALL clear after one cycle even if no push occurs.
REQ-021 br_taken_o SHALL be 1 in the accept cycle of opcode 6'h04 (beq) with rs_data == rt_data, and 0 otherwise.
REQ-022 jmp_o SHALL be 1 in the accept cycle of opcode 6'h02 (j), and 0 otherwise.
REQ-023 For beq, target_o SHALL be pc_i + (imm << 2), mod 2^XLEN.
REQ-024 For j, target_o SHALL be {pc_i[XLEN-1:28], inst_i[25:0], 2'b00}.
REQ-025 target_o SHALL be 0 when neither br_taken_o nor jmp_o is asserted.
REQ-026 Branch and jump instructions SHALL still be pushed into the FIFO.
REQ-027 flush_i SHALL set count = 0 and clear load_pend at the next edge; register-file writes in that cycle SHALL still complete.
REQ-028 flush_i SHALL take priority over a simultaneous pop.

Reset
REQ-029 On rst_i = 1 at a clock edge, all registers, FIFO entries, count and load_pend SHALL become 0; out_valid_o, br_taken_o and jmp_o SHALL be 0 in the following cycle.
REQ-030 Reset mid-operation SHALL discard buffered entries without any pop handshake, and SHALL override a simultaneous wb_we_i.
REQ-031 While rst_i = 1, in_ready_o SHALL be 0.

Configuration
REQ-032 With macro DECODE_BYPASS_EN defined, a read whose address equals wb_addr_i (nonzero) while wb_we_i = 1 SHALL return wb_data_i in the same cycle.
REQ-033 Without DECODE_BYPASS_EN, such a read SHALL return the old value; the new value SHALL be visible from the next cycle.

Verification
REQ-034 Write r5 = 0x1234 via wb; next cycle push inst with rs = 5 -> out_rs_data_o = 0x00001234, out_valid_o = 1 one cycle later.
REQ-035 Hold out_ready_i = 0 and push 3 instructions -> third stalls with in_ready_o = 0; release -> three outputs pop in order.
REQ-036 Push lw rt = 7, then immediately add rs = 7 -> in_ready_o = 0 for one cycle, then add is accepted; using rt = 0 instead -> no stall.
REQ-037 beq, pc = 0x100, imm = 0xFFFF, r1 == r2 -> br_taken_o = 1, target_o = 0xFC; j with pc 0x4000_0000, target field 0x10 -> jmp_o = 1, target_o = 0x4000_0040.
REQ-038 wb write r3 = 0xAA in the same cycle as a read of rs = 3 -> 0xAA with DECODE_BYPASS_EN, previous value without it.
REQ-039 With 2 entries buffered, assert flush_i together with out_ready_i -> count = 0 next cycle; then assert rst_i mid-stream -> all outputs 0 and r5 reads 0.
